// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared encodings, captured-op record and access helpers for the MEM stage
package mem_stage_pkg;
  localparam int DATA_W = 32;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  typedef enum logic [1:0] {IDLE, WAIT, VALID} state_t;
  typedef struct packed {
    logic ld;
    logic wb_sel;
    logic sign_ext;
    logic mis;
    logic reg_wr;
    logic [1:0] size;
    logic [1:0] off;
    logic [DATA_W-1:0] alu;
  } ctl_t;
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return size == SZ_HALF ? off[0] : size == SZ_BYTE ? 1'b0 : off != 2'd0;
  endfunction
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    return size == SZ_BYTE ? 4'b0001 << off : size == SZ_HALF ? 4'b0011 << off : 4'b1111;
  endfunction
endpackage

// File: rtl/mem_stage_pipelined_if.sv
// mem_stage_pipelined_if: EX-side request and WB-side result handshakes of the MEM stage
interface mem_stage_pipelined_if #(parameter int REG_ADDR_W = 5);
  import mem_stage_pkg::*;
  logic in_valid, in_ready, mem_rd, mem_wr, wb_sel, reg_wr, sign_ext;
  logic [1:0] size;
  logic [DATA_W-1:0] alu_res, store_data, wb_data;
  logic [REG_ADDR_W-1:0] rd, rd_out;
  logic out_valid, out_ready, reg_wr_out, misalign_err;
  modport master (
    output in_valid, mem_rd, mem_wr, wb_sel, reg_wr, size, sign_ext, alu_res, store_data, rd, out_ready,
    input in_ready, out_valid, wb_data, rd_out, reg_wr_out, misalign_err
  );
  modport slave (
    input in_valid, mem_rd, mem_wr, wb_sel, reg_wr, size, sign_ext, alu_res, store_data, rd, out_ready,
    output in_ready, out_valid, wb_data, rd_out, reg_wr_out, misalign_err
  );
endinterface

// File: rtl/data_mem_bytewise.sv
// data_mem_bytewise: byte-enable synchronous RAM with a READ_LAT-deep read pipeline
module data_mem_bytewise
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] pipe_q [READ_LAT];
  logic [DATA_W-1:0] pipe_d [READ_LAT];
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
  always_comb begin
    pipe_d = pipe_q;
    pipe_d[0] = re ? mem[addr] : pipe_q[0];
    for (int i = 1; i < READ_LAT; i++) pipe_d[i] = pipe_q[i-1];
  end
  always_ff @(posedge clk)
    if (rst) pipe_q <= '{default: '0};
    else pipe_q <= pipe_d;
  assign rdata = pipe_q[READ_LAT-1];
endmodule

// File: rtl/mem_stage_pipelined.sv
// mem_stage_pipelined: MEM stage with byte/half/word access, load latency and valid/ready stalls
module mem_stage_pipelined
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int READ_LAT = 1,
  parameter int REG_ADDR_W = 5
) (
  input logic clk,
  input logic rst,
  mem_stage_pipelined_if.slave bus
);
  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  ctl_t ctl_q, ctl_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] rdata, ld_data;
  logic [15:0] sh;
  logic [1:0] off;
  logic acc, ld, mis;
  assign off = bus.alu_res[1:0];
  assign bus.in_ready = state_q == IDLE || (state_q == VALID && bus.out_ready);
  assign acc = bus.in_valid && bus.in_ready && !rst;
  assign ld = bus.mem_rd && !bus.mem_wr;
  assign mis = (bus.mem_rd || bus.mem_wr) && misaligned(bus.size, off);
  data_mem_bytewise #(.ADDR_W(ADDR_W), .READ_LAT(READ_LAT)) u_mem (
    .clk,
    .rst,
    .re(acc && ld),
    .we(acc && bus.mem_wr && !mis ? byte_en(bus.size, off) : 4'b0000),
    .addr(bus.alu_res[ADDR_W+1:2]),
    .wdata(bus.size == SZ_BYTE ? {4{bus.store_data[7:0]}} :
           bus.size == SZ_HALF ? {2{bus.store_data[15:0]}} : bus.store_data),
    .rdata
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ctl_d = ctl_q;
    rd_d = rd_q;
    if (acc) begin
      state_d = ld && READ_LAT > 1 ? WAIT : VALID;
      cnt_d = 2'(READ_LAT - 2);
      ctl_d = '{ld: ld, wb_sel: bus.wb_sel, sign_ext: bus.sign_ext, mis: mis, reg_wr: bus.reg_wr,
                size: bus.size, off: off, alu: bus.alu_res};
      rd_d = bus.rd;
    end else if (state_q == WAIT) begin
      state_d = cnt_q == 2'd0 ? VALID : WAIT;
      cnt_d = cnt_q - 2'd1;
    end else if (state_q == VALID && bus.out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      ctl_q <= '0;
      rd_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ctl_q <= ctl_d;
      rd_q <= rd_d;
    end
  // read data stays parked in the RAM pipeline, so only lane select and extension follow the flops
  assign sh = 16'(rdata >> {ctl_q.off, 3'b000});
  assign ld_data = ctl_q.mis ? '0 :
                   ctl_q.size == SZ_BYTE ? {{24{ctl_q.sign_ext & sh[7]}}, sh[7:0]} :
                   ctl_q.size == SZ_HALF ? {{16{ctl_q.sign_ext & sh[15]}}, sh[15:0]} : rdata;
  assign bus.out_valid = state_q == VALID;
  assign bus.wb_data = ctl_q.ld && ctl_q.wb_sel ? ld_data : ctl_q.alu;
  assign bus.rd_out = rd_q;
  assign bus.reg_wr_out = ctl_q.reg_wr && !ctl_q.mis;
  assign bus.misalign_err = bus.out_valid && ctl_q.mis;
endmodule
